vcmp_mask_packer: RTL and testbench

//   Downstream of the vector add/min/max/compare unit. Consumes its per-beat compare results
//   and compacts them into dense mask words, one bit per element.

---
 rtl/vcmp_mask_packer_pkg.sv | 16 +
 rtl/vcmp_mask_extract.sv | 27 ++
 rtl/vcmp_mask_packer.sv | 93 +++++++++
 tb/tb_vcmp_mask_packer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vcmp_mask_packer_pkg.sv
// Shared SEW encodings and helpers for the compare-mask packer.
package vcmp_mask_packer_pkg;

    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    localparam int MASK_NBITS_WIDTH = 7;

    // Elements carried by one 64-bit beat: 8, 4, 2 or 1.
    function automatic logic [3:0] elems_per_beat(input logic [1:0] sew);
        return 4'd8 >> sew;
    endfunction

endpackage

// File: rtl/vcmp_mask_extract.sv
// Gathers the per-element compare flags of one beat into the low bits of a byte.
// Latency: combinational. Backpressure: none.
module vcmp_mask_extract
    import vcmp_mask_packer_pkg::*;
(
    input  logic [63:0] in_vec,
    input  logic [1:0]  sew,
    output logic [7:0]  packed_flags,
    output logic [3:0]  n
);

    logic [5:0] idx;

    assign n = elems_per_beat(sew);

    always_comb begin
        packed_flags = '0;
        idx          = '0;
        for (int j = 0; j < 8; j++) begin
            idx = 6'(j << sew);
            if (4'(j) < n) begin
                packed_flags[j] = in_vec[idx];
            end
        end
    end

endmodule

// File: rtl/vcmp_mask_packer.sv
// Packs per-beat compare flags into 64-bit mask words; output registered 1 cycle after the emitting beat.
// Backpressure: none, one beat accepted per cycle and at most one word emitted per cycle.
module vcmp_mask_packer
    import vcmp_mask_packer_pkg::*;
#(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int SEW_WIDTH      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQ_DATA_WIDTH-1:0]   in_vec,
    input  logic                        in_valid,
    input  logic [SEW_WIDTH-1:0]        in_sew,
    input  logic                        in_last,
    input  logic [REQ_ADDR_WIDTH-1:0]   in_addr,
    output logic [REQ_DATA_WIDTH-1:0]   out_vec,
    output logic                        out_valid,
    output logic [REQ_ADDR_WIDTH-1:0]   out_addr,
    output logic [MASK_NBITS_WIDTH-1:0] out_nbits
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [0:0]                  state;
    logic [63:0]                 acc;
    logic [6:0]                  ptr;
    logic [REQ_ADDR_WIDTH-1:0]   word_addr;

    logic [7:0]                  packed_flags;
    logic [3:0]                  n;
    logic [6:0]                  base_ptr;
    logic [63:0]                 base_acc;
    logic [6:0]                  ptr_next;
    logic [63:0]                 merged;
    logic [REQ_ADDR_WIDTH-1:0]   cur_addr;
    logic                        full;
    logic                        emit;
    logic [6:0]                  nbits;

    vcmp_mask_extract u_extract (
        .in_vec       (in_vec),
        .sew          (in_sew),
        .packed_flags (packed_flags),
        .n            (n)
    );

    // A first beat always starts a fresh word regardless of leftover registers.
    assign base_ptr = (state == ST_IDLE) ? 7'd0 : ptr;
    assign base_acc = (state == ST_IDLE) ? 64'd0 : acc;
    assign cur_addr = (state == ST_IDLE) ? in_addr : word_addr;

    assign ptr_next = base_ptr + {3'b000, n};
    assign merged   = base_acc | ({56'd0, packed_flags} << base_ptr);

    // >= rather than == so an illegal mid-instruction SEW change still flushes instead of wrapping.
    assign full  = (ptr_next >= 7'd64);
    assign emit  = full || in_last;
    assign nbits = full ? 7'd64 : ptr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            ptr       <= '0;
            word_addr <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_nbits <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                state <= in_last ? ST_IDLE : ST_ACCUM;
                if (emit) begin
                    out_vec   <= merged;
                    out_nbits <= nbits;
                    out_addr  <= cur_addr;
                    out_valid <= 1'b1;
                    word_addr <= cur_addr + {{(REQ_ADDR_WIDTH-1){1'b0}}, 1'b1};
                    acc       <= '0;
                    ptr       <= '0;
                end else begin
                    acc       <= merged;
                    ptr       <= ptr_next;
                    word_addr <= cur_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_vcmp_mask_packer.sv
// Scoreboard bench: an element-list reference model predicts mask words, a monitor checks each out_valid pulse.
module tb_vcmp_mask_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_vec;
    logic        in_valid;
    logic [1:0]  in_sew;
    logic        in_last;
    logic [31:0] in_addr;
    logic [63:0] out_vec;
    logic        out_valid;
    logic [31:0] out_addr;
    logic [6:0]  out_nbits;

    always #5 clk = ~clk;

    vcmp_mask_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_sew    (in_sew),
        .in_last   (in_last),
        .in_addr   (in_addr),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_nbits (out_nbits)
    );

    typedef struct {
        logic [63:0] vec;
        logic [31:0] addr;
        int          nbits;
    } exp_t;

    exp_t        exp_q[$];
    bit          elems[$];
    logic [31:0] m_addr;
    bit          m_busy;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: an instruction is a flat list of element flags cut into 64-element words.
    task automatic model_emit();
        exp_t e;
        e.vec   = '0;
        e.nbits = elems.size();
        for (int i = 0; i < elems.size(); i++) e.vec[i] = elems[i];
        e.addr = m_addr;
        exp_q.push_back(e);
        elems.delete();
        m_addr++;
    endtask

    task automatic beat(input logic [63:0] v, input int sew, input bit last, input logic [31:0] a);
        int width;
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = v;
        in_sew   = 2'(sew);
        in_last  = last;
        in_addr  = a;
        if (!m_busy) begin
            m_addr = a;
            m_busy = 1'b1;
        end
        width = 1 << sew;
        for (int j = 0; j < 64 / width / 8 * 8 / 8 * 8 / 8; j++) begin end
        for (int j = 0; j < 8 / width; j++) elems.push_back(v[j * width * 8 / 8 * (8 / 8)]);
        if (elems.size() == 64 || (last && elems.size() > 0)) model_emit();
        if (last) m_busy = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_vec   = {$urandom, $urandom};
            in_addr  = $urandom;
        end
    endtask

    function automatic logic [63:0] spread(input logic [7:0] f, input int sew);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < (8 >> sew); j++) r[j * (1 << sew)] = f[j];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got vec 0x%0h addr 0x%0h nbits %0d, expected no output",
                         out_vec, out_addr, out_nbits);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_vec", out_vec, e.vec);
                check("out_addr", {32'd0, out_addr}, {32'd0, e.addr});
                check("out_nbits", {57'd0, out_nbits}, 64'(e.nbits));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_vec   = '0;
        in_sew   = '0;
        in_last  = 1'b0;
        in_addr  = '0;
        m_busy   = 1'b0;
        m_addr   = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_vec", out_vec, 64'd0);
        check("reset_out_addr", {32'd0, out_addr}, 64'd0);
        check("reset_out_nbits", {57'd0, out_nbits}, 64'd0);
        rst = 1'b0;
        idle(2);

        // Full SEW=8 word, flag bytes 0x01..0x08.
        for (int b = 0; b < 8; b++) beat(spread(8'(b + 1), 0), 0, 1'b0, 32'h40);
        idle(3);

        // SEW=64 partial word of 3 elements.
        beat(64'h1, 3, 1'b0, 32'h10);
        beat(64'hFFFF_FFFF_FFFF_FFFE, 3, 1'b0, 32'h99);
        beat(64'h1, 3, 1'b1, 32'h77);
        idle(3);

        // SEW=16 full word coinciding with last.
        for (int b = 0; b < 16; b++) beat('1, 1, b == 15, 32'h200);
        idle(4);

        // SEW=8 word overflowing into a second 8-bit word.
        for (int b = 0; b < 9; b++) beat(64'h0101_0101_0101_0101, 0, b == 8, 32'h300);
        idle(3);

        // First test again with random idle gaps.
        for (int b = 0; b < 8; b++) begin
            beat(spread(8'(b + 1), 0), 0, 1'b0, 32'h40);
            idle($urandom_range(0, 3));
        end
        idle(3);

        // Reset mid-accumulation discards the partial word.
        for (int b = 0; b < 3; b++) beat({$urandom, $urandom}, 2, 1'b0, 32'h55);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        elems.delete();
        m_busy = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        beat(64'h1_0000_0001, 2, 1'b1, 32'h80);
        idle(3);

        // Random instructions, with back-to-back starts when the gap draws zero.
        for (int t = 0; t < 30; t++) begin
            int sew;
            int nb;
            logic [31:0] base;
            sew  = $urandom_range(0, 3);
            nb   = $urandom_range(1, 2 * (8 << sew) + 3);
            base = $urandom;
            for (int b = 0; b < nb; b++) begin
                beat({$urandom, $urandom}, sew, b == nb - 1, base);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            idle($urandom_range(0, 2));
        end

        idle(5);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
